// File: rtl/sha256_pkg.sv
// SHA-224/SHA-256 shared definitions: FSM state type, initial hash values,
// round constant table and the bitwise helper functions used by the round
// logic and message schedule. No ports; imported by the core and round files.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COMP  = 2'd1,
        ST_FINAL = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // H0 occupies the most significant word.
    localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    function automatic logic [31:0] k_const(input logic [5:0] idx);
        logic [31:0] k;
        k = '0;
        case (idx)
            6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7; 6'd63: k = 32'hc67178f2;
            default: k = '0;
        endcase
        return k;
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Message schedule sigmas.
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // Compression-function sigmas.
    function automatic logic [31:0] Sig0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [31:0] Sig1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-2 compression round, purely combinational (zero latency, no flow control).
// Ports: i_state = {a,b,c,d,e,f,g,h} (a in [255:224]), i_k round constant,
// i_w schedule word, o_state = updated {a..h}.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] i_state,
    input  logic [31:0]  i_k,
    input  logic [31:0]  i_w,
    output logic [255:0] o_state
);

    logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic [31:0] w_t1, w_t2;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;

    assign w_t1 = w_h + Sig1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
    assign w_t2 = Sig0(w_a) + maj(w_a, w_b, w_c);

    assign o_state = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

// File: rtl/sha256_core_multi.sv
// SHA-224/SHA-256 block compression, RPC rounds per clock, multi-block messages.
// Latency: accept at edge 0, rounds on edges 1..64/RPC, feed-forward at 64/RPC+1.
// Backpressure: blk_ready only in IDLE; digest held with dig_valid until dig_ready.
// Ports: clk/rst (sync, active-high); blk_valid/blk_ready/blk_data/blk_first/
// blk_last/mode_224 block input; dig_valid/dig_ready/digest output; busy status.
module sha256_core_multi #(
    parameter int RPC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    input  logic         mode_224,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [255:0] digest,
    output logic         busy
);
    import sha256_pkg::*;

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
        $fatal(1, "sha256_core_multi: RPC must be 1, 2, 4 or 8");
    end

    localparam int LAST_T = 64 - RPC;

    state_t       r_state;
    logic [255:0] r_h;
    logic [255:0] r_wv;          // working variables a..h
    logic [31:0]  r_w [16];      // r_w[0] is W[t]
    logic [5:0]   r_t;
    logic         r_mode;
    logic         r_last;
    logic         r_blk_ready;
    logic         r_dig_valid;
    logic         r_busy;

    logic [31:0]  w_next_w [16];
    logic [255:0] w_final;

    // Extend the schedule window by RPC words; later new words depend on
    // earlier new words, hence the local chain.
    always_comb begin
        logic [31:0] v_ext [16+RPC];
        for (int i = 0; i < 16; i++) begin
            v_ext[i] = r_w[i];
        end
        for (int j = 0; j < RPC; j++) begin
            v_ext[16+j] = sig1(v_ext[14+j]) + v_ext[9+j] + sig0(v_ext[1+j]) + v_ext[j];
        end
        for (int i = 0; i < 16; i++) begin
            w_next_w[i] = v_ext[RPC+i];
        end
    end

    // Rounds t..t+RPC-1 chained; round j consumes window word j.
    for (genvar j = 0; j < RPC; j++) begin : g_rnd
        logic [255:0] w_in;
        logic [255:0] w_out;
        logic [31:0]  w_k;

        if (j == 0) begin : g_head
            assign w_in = r_wv;
        end else begin : g_tail
            assign w_in = g_rnd[j-1].w_out;
        end

        assign w_k = k_const(r_t + 6'(j));

        sha256_round u_round (
            .i_state (w_in),
            .i_k     (w_k),
            .i_w     (r_w[j]),
            .o_state (w_out)
        );
    end

    assign w_final = g_rnd[RPC-1].w_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_h         <= '0;
            r_wv        <= '0;
            r_t         <= '0;
            r_mode      <= 1'b0;
            r_last      <= 1'b0;
            r_blk_ready <= 1'b1;
            r_dig_valid <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= '0;
            end
        end else begin
            case (r_state)
                // blk_ready is high throughout IDLE, so valid alone is an accept.
                ST_IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            r_w[i] <= blk_data[511-32*i -: 32];
                        end
                        if (blk_first) begin
                            r_h    <= mode_224 ? IV224 : IV256;
                            r_wv   <= mode_224 ? IV224 : IV256;
                            r_mode <= mode_224;
                        end else begin
                            r_wv <= r_h;
                        end
                        r_last      <= blk_last;
                        r_t         <= '0;
                        r_state     <= ST_COMP;
                        r_blk_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_COMP: begin
                    r_wv <= w_final;
                    for (int i = 0; i < 16; i++) begin
                        r_w[i] <= w_next_w[i];
                    end
                    r_t <= r_t + 6'(RPC);
                    if (r_t == 6'(LAST_T)) begin
                        r_state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        r_h[255-32*i -: 32] <= r_h[255-32*i -: 32] + r_wv[255-32*i -: 32];
                    end
                    r_busy <= 1'b0;
                    if (r_last) begin
                        r_state     <= ST_OUT;
                        r_dig_valid <= 1'b1;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_blk_ready <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (dig_ready) begin
                        r_state     <= ST_IDLE;
                        r_dig_valid <= 1'b0;
                        r_blk_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign blk_ready = r_blk_ready;
    assign dig_valid = r_dig_valid;
    assign busy      = r_busy;
    // H7 keeps its full value for chaining; only the visible digest is truncated.
    assign digest    = r_mode ? {r_h[255:32], 32'h0} : r_h;

endmodule

// File: tb/tb_sha256_core_multi.sv
module tb_sha256_core_multi;

    localparam int N = 4;   // instance g runs RPC = 1 << g

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         blk_valid [N];
    logic         blk_first [N];
    logic         blk_last  [N];
    logic         mode_224  [N];
    logic         dig_ready [N];
    logic [511:0] blk_data  [N];
    logic         blk_ready [N];
    logic         dig_valid [N];
    logic         busy      [N];
    logic [255:0] digest    [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        sha256_core_multi #(.RPC(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .blk_valid (blk_valid[g]),
            .blk_ready (blk_ready[g]),
            .blk_data  (blk_data[g]),
            .blk_first (blk_first[g]),
            .blk_last  (blk_last[g]),
            .mode_224  (mode_224[g]),
            .dig_valid (dig_valid[g]),
            .dig_ready (dig_ready[g]),
            .digest    (digest[g]),
            .busy      (busy[g])
        );
    end

    localparam logic [31:0] K_TB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [255:0] H256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] H224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_2A    = 512'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f70718000000000000000;
    localparam logic [511:0] BLK_2B    = {480'h0, 32'h000001c0};

    localparam logic [255:0] DIG_ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
    localparam logic [255:0] DIG_2BLK   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] DIG_EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] model_compress(input logic [255:0] h_in, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] s0, s1, t1, t2;
        logic [255:0] h_out;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = h_in[255-32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TB[i] + w[i];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        h_out = '0;
        for (int i = 0; i < 8; i++) h_out[255-32*i -: 32] = h_in[255-32*i -: 32] + v[i];
        return h_out;
    endfunction

    function automatic logic [255:0] model_digest(input logic [511:0] blks [$], input logic m);
        logic [255:0] h;
        h = m ? H224 : H256;
        foreach (blks[i]) h = model_compress(h, blks[i]);
        if (m) h[31:0] = 32'h0;
        return h;
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for the end of compression of an accepted block (the bench is
    // just after the accept edge) and checks latency, flags and digest.
    task automatic finish_block(input int k, input logic l, input int hold,
                                input logic [255:0] exp, input logic ack);
        int e;
        e = 0;
        while (!(dig_valid[k] === 1'b1 || blk_ready[k] === 1'b1) && e < 200) begin
            step();
            e++;
        end
        check($sformatf("latency_k%0d", k), 256'(e), 256'(64 / (1 << k) + 1));
        check("busy_after_final", busy[k], 1'b0);
        if (l) begin
            check("dig_valid_last", dig_valid[k], 1'b1);
            check("blk_ready_out", blk_ready[k], 1'b0);
            check("digest", digest[k], exp);
            if (ack) begin
                for (int i = 0; i < hold; i++) begin
                    step();
                    check("hold_dig_valid", dig_valid[k], 1'b1);
                    check("hold_digest", digest[k], exp);
                end
                dig_ready[k] = 1'b1;
                step();
                dig_ready[k] = 1'b0;
                check("dig_valid_drop", dig_valid[k], 1'b0);
                check("blk_ready_back", blk_ready[k], 1'b1);
            end
        end else begin
            check("no_dig_mid_msg", dig_valid[k], 1'b0);
            check("blk_ready_mid_msg", blk_ready[k], 1'b1);
        end
    endtask

    task automatic offer_accept(input int k, input logic [511:0] d, input logic f,
                                input logic l, input logic m);
        int n;
        blk_data[k] = d; blk_first[k] = f; blk_last[k] = l; mode_224[k] = m;
        blk_valid[k] = 1'b1;
        n = 0;
        while (blk_ready[k] !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("accept_wait", 256'(n < 200), 256'(1));
        step();
        blk_valid[k] = 1'b0;
        check("busy_after_accept", busy[k], 1'b1);
        check("rdy_after_accept", blk_ready[k], 1'b0);
    endtask

    task automatic send_block(input int k, input logic [511:0] d, input logic f, input logic l,
                              input logic m, input int hold, input logic [255:0] exp, input logic ack);
        offer_accept(k, d, f, l, m);
        finish_block(k, l, hold, exp, ack);
    endtask

    task automatic run_msg(input int k, input logic [511:0] blks [$], input logic m,
                           input logic toggle, input int hold);
        logic [255:0] exp;
        logic bm;
        exp = model_digest(blks, m);
        foreach (blks[i]) begin
            bm = (i == 0) ? m : (toggle ? ~m : m);
            send_block(k, blks[i], i == 0, i == blks.size() - 1, bm, hold, exp, 1'b1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [511:0] q [$];
        logic [511:0] rb;
        int k;
        int nb;

        for (int i = 0; i < N; i++) begin
            blk_valid[i] = 1'b0; blk_first[i] = 1'b0; blk_last[i] = 1'b0;
            mode_224[i] = 1'b0; dig_ready[i] = 1'b0; blk_data[i] = '0;
        end
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("rst_blk_ready", blk_ready[i], 1'b1);
            check("rst_dig_valid", dig_valid[i], 1'b0);
            check("rst_busy", busy[i], 1'b0);
            check("rst_digest", digest[i], '0);
        end

        // Chaining from H=0 after reset; mode_224 must be ignored (not first).
        send_block(2, BLK_ABC, 1'b0, 1'b1, 1'b1, 0, model_compress('0, BLK_ABC), 1'b1);

        // Known vectors.
        send_block(0, BLK_ABC, 1'b1, 1'b1, 1'b0, 2, DIG_ABC256, 1'b1);
        send_block(2, BLK_ABC, 1'b1, 1'b1, 1'b1, 0, DIG_ABC224, 1'b1);
        send_block(1, BLK_2A, 1'b1, 1'b0, 1'b0, 0, '0, 1'b1);
        send_block(1, BLK_2B, 1'b0, 1'b1, 1'b0, 1, DIG_2BLK, 1'b1);

        // Output backpressure with a new block waiting.
        send_block(3, BLK_EMPTY, 1'b1, 1'b1, 1'b0, 0, DIG_EMPTY, 1'b0);
        blk_data[3] = BLK_ABC; blk_first[3] = 1'b1; blk_last[3] = 1'b1; mode_224[3] = 1'b0;
        blk_valid[3] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_blk_ready", blk_ready[3], 1'b0);
            check("bp_dig_valid", dig_valid[3], 1'b1);
            check("bp_digest", digest[3], DIG_EMPTY);
        end
        dig_ready[3] = 1'b1;
        step();
        dig_ready[3] = 1'b0;
        check("bp_release_valid", dig_valid[3], 1'b0);
        check("bp_release_ready", blk_ready[3], 1'b1);
        step();
        blk_valid[3] = 1'b0;
        check("bp_next_accepted", busy[3], 1'b1);
        finish_block(3, 1'b1, 0, DIG_ABC256, 1'b1);

        // Reset in the middle of compression, at round 30.
        offer_accept(0, BLK_ABC, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step();
        check("pre_rst_busy", busy[0], 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_blk_ready", blk_ready[0], 1'b1);
        check("mid_rst_dig_valid", dig_valid[0], 1'b0);
        check("mid_rst_busy", busy[0], 1'b0);
        check("mid_rst_digest", digest[0], '0);
        for (int i = 0; i < 40; i++) step();
        check("no_digest_after_rst", dig_valid[0], 1'b0);
        send_block(0, BLK_ABC, 1'b1, 1'b1, 1'b0, 0, DIG_ABC256, 1'b1);

        // Mode latching: second block toggles mode_224.
        for (int m = 0; m < 2; m++) begin
            q.delete();
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < 16; w++) rb[511-32*w -: 32] = $urandom;
                q.push_back(rb);
            end
            run_msg(1, q, m[0], 1'b1, 0);
        end

        // Randomized messages across all RPC values.
        for (int it = 0; it < 14; it++) begin
            k  = $urandom_range(0, N - 1);
            nb = $urandom_range(1, 3);
            q.delete();
            for (int b = 0; b < nb; b++) begin
                for (int w = 0; w < 16; w++) rb[511-32*w -: 32] = $urandom;
                q.push_back(rb);
            end
            run_msg(k, q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
